// File: rtl/dma_mu_master.sv
// dma_mu_master: word-copy DMA engine driving a single-request memory unit.
// Each word is one read (src) followed by one write (dst), with one idle
// bus cycle after every completed request. irq_done pulses after the last word.
// Optional fill mode is compiled in with the macro DMA_MU_MASTER_FILL_EN.
// In fill mode the reads are skipped and cfg_pattern is written to len words.
module dma_mu_master #(
    parameter int unsigned LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         cfg_src,
    input  logic [31:0]         cfg_dst,
    input  logic [LEN_BITS-1:0] cfg_len,
    input  logic                cfg_go,
`ifdef DMA_MU_MASTER_FILL_EN
    input  logic                cfg_fill,
    input  logic [31:0]         cfg_pattern,
`endif
    output logic                busy,
    output logic                irq_done,
    output logic                mu_start,
    output logic [31:0]         mu_addr,
    output logic [31:0]         mu_data,
    output logic                mu_we,
    input  logic [31:0]         mu_q,
    input  logic                mu_done
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       src_q, src_nx;
    logic [AW-1:0]       dst_q, dst_nx;
    logic [AW-1:0]       buf_q, buf_nx;
    logic [AW-1:0]       addr_q, addr_nx;
    logic [LEN_BITS-1:0] len_q, len_nx;
    logic                start_q, start_nx;
    logic                we_q, we_nx;
    logic                busy_q, busy_nx;
    logic                irq_q, irq_nx;
    logic                fill_q, fill_nx;
    logic                go_fill;
    logic [AW-1:0]       go_pattern;
    logic                bus_done;

`ifdef DMA_MU_MASTER_FILL_EN
    assign go_fill    = cfg_fill;
    assign go_pattern = cfg_pattern;
`else
    assign go_fill    = 1'b0;
    assign go_pattern = '0;
`endif

    // A completion only counts while our own request is outstanding
    assign bus_done = start_q && mu_done;

    assign busy     = busy_q;
    assign irq_done = irq_q;
    assign mu_start = start_q;
    assign mu_addr  = addr_q;
    assign mu_data  = buf_q;
    assign mu_we    = we_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            src_q   <= src_nx;
            dst_q   <= dst_nx;
            buf_q   <= buf_nx;
            addr_q  <= addr_nx;
            len_q   <= len_nx;
            start_q <= start_nx;
            we_q    <= we_nx;
            busy_q  <= busy_nx;
            irq_q   <= irq_nx;
            fill_q  <= fill_nx;
        end
    end

    // Next state and next values of the bus-side registers
    always_comb begin
        state_nx = state;
        src_nx   = src_q;
        dst_nx   = dst_q;
        buf_nx   = buf_q;
        addr_nx  = addr_q;
        len_nx   = len_q;
        start_nx = start_q;
        we_nx    = we_q;
        irq_nx   = 1'b0;
        fill_nx  = fill_q;

        case (state)
            IDLE: begin
                if (cfg_go) begin
                    if (cfg_len == '0) begin
                        state_nx = FINISH;
                    end else begin
                        src_nx   = cfg_src;
                        dst_nx   = cfg_dst;
                        len_nx   = cfg_len;
                        fill_nx  = go_fill;
                        start_nx = 1'b1;
                        if (go_fill) begin
                            state_nx = WR_REQ;
                            addr_nx  = cfg_dst;
                            we_nx    = 1'b1;
                            buf_nx   = go_pattern;
                        end else begin
                            state_nx = RD_REQ;
                            addr_nx  = cfg_src;
                            we_nx    = 1'b0;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (bus_done) begin
                    buf_nx   = mu_q;
                    state_nx = WR_REQ;
                    start_nx = 1'b0;
                    addr_nx  = dst_q;
                    we_nx    = 1'b1;
                end else begin
                    start_nx = 1'b1;
                end
            end
            WR_REQ: begin
                if (bus_done) begin
                    src_nx   = src_q + AW'(1);
                    dst_nx   = dst_q + AW'(1);
                    len_nx   = len_q - LEN_BITS'(1);
                    start_nx = 1'b0;
                    if (len_q != LEN_BITS'(1)) begin
                        if (fill_q) begin
                            state_nx = WR_REQ;
                            addr_nx  = dst_q + AW'(1);
                            we_nx    = 1'b1;
                        end else begin
                            state_nx = RD_REQ;
                            addr_nx  = src_q + AW'(1);
                            we_nx    = 1'b0;
                        end
                    end else begin
                        state_nx = FINISH;
                        we_nx    = 1'b0;
                    end
                end else begin
                    start_nx = 1'b1;
                end
            end
            FINISH: begin
                state_nx = IDLE;
                irq_nx   = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_dma_mu_master.sv
// tb_dma_mu_master: randomized bench for dma_mu_master with a transaction-level
// model (expected bus operation list + completion timing) and a memory responder.
module tb_dma_mu_master;

    localparam int unsigned LB = 16;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        int          cyc;
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        bit          fill;
        logic [31:0] pat;
    } go_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cfg_src, cfg_dst;
    logic [LB-1:0] cfg_len;
    logic          cfg_go;
`ifdef DMA_MU_MASTER_FILL_EN
    logic          cfg_fill;
    logic [31:0]   cfg_pattern;
`endif
    logic          busy, irq_done, mu_start, mu_we, mu_done;
    logic [31:0]   mu_addr, mu_data, mu_q;

    dma_mu_master #(.LEN_BITS(LB)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_src     (cfg_src),
        .cfg_dst     (cfg_dst),
        .cfg_len     (cfg_len),
        .cfg_go      (cfg_go),
`ifdef DMA_MU_MASTER_FILL_EN
        .cfg_fill    (cfg_fill),
        .cfg_pattern (cfg_pattern),
`endif
        .busy        (busy),
        .irq_done    (irq_done),
        .mu_start    (mu_start),
        .mu_addr     (mu_addr),
        .mu_data     (mu_data),
        .mu_we       (mu_we),
        .mu_q        (mu_q),
        .mu_done     (mu_done)
    );

    always #10 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // model state
    bit  m_active = 1'b0;
    int  m_go_c = 0;
    int  m_end_c = -1;
    op_t exp_q[$];
    go_t go_q[$];
    op_t ev_q[$];
    op_t log_q[$];
    int  irq_log[$];
    int  start_cycles = 0;
    int  last_go_c = 0;

    // responder state
    int  k = 0;
    int  lat = 2;
    bit  hold = 1'b0;
    bit  spur_en = 1'b0;
    int  inject_req = 0;
    int  inject_ack = 0;

    // compare-loop scratch
    bit          done_now;
    bit          exp_busy, exp_irq;
    bit          prev_start = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    op_t         op, e, rop;
    go_t         g;

    logic [31:0] t1_addr [6] = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
    logic        t1_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic accept(input go_t gg);
        m_active = 1'b1;
        m_go_c   = gg.cyc;
        m_end_c  = (gg.len == 0) ? gg.cyc : -1;
        exp_q.delete();
        for (int i = 0; i < gg.len; i++) begin
            op_t r, w;
            r.cyc = 0; r.we = 1'b0; r.addr = gg.src + 32'(i); r.data = '0;
            w.cyc = 0; w.we = 1'b1; w.addr = gg.dst + 32'(i);
            w.data = gg.fill ? gg.pat : mem_val(gg.src + 32'(i));
            if (!gg.fill) exp_q.push_back(r);
            exp_q.push_back(w);
        end
    endtask

    task automatic issue_go(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit fill, input logic [31:0] pat);
        go_t gg;
        @(negedge clk);
        cfg_src = src;
        cfg_dst = dst;
        cfg_len = LB'(len);
        cfg_go  = 1'b1;
        gg.cyc = cyc; gg.src = src; gg.dst = dst; gg.len = len; gg.pat = pat;
`ifdef DMA_MU_MASTER_FILL_EN
        cfg_fill    = fill;
        cfg_pattern = pat;
        gg.fill     = fill;
`else
        gg.fill     = 1'b0;
`endif
        last_go_c = cyc;
        go_q.push_back(gg);
        @(negedge clk);
        cfg_go  = 1'b0;
        cfg_src = $urandom;
        cfg_dst = $urandom;
        cfg_len = LB'($urandom);
    endtask

    task automatic wait_idle(input int budget, input bit stray);
        int n = 0;
        while ((m_active || go_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (stray && $urandom_range(0, 24) == 0)
                issue_go($urandom, $urandom, $urandom_range(0, 3), 1'($urandom), $urandom);
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: transfer still active after %0d cycles, required completion", n);
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        irq_log.delete();
        start_cycles = 0;
    endtask

    function automatic int count_we(input logic we);
        int c = 0;
        foreach (log_q[i]) if (log_q[i].we == we) c++;
        return c;
    endfunction

    initial begin
        reset   = 1'b1;
        cfg_go  = 1'b0;
        cfg_src = '0;
        cfg_dst = '0;
        cfg_len = '0;
`ifdef DMA_MU_MASTER_FILL_EN
        cfg_fill    = 1'b0;
        cfg_pattern = '0;
`endif
        mu_done = 1'b0;
        mu_q    = '0;

        fork
            // compare process: model update then per-cycle output checks
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                if (reset) begin
                    m_active = 1'b0;
                    exp_q.delete();
                    go_q.delete();
                    ev_q.delete();
                    chk("rst_mu_start", mu_start, 0);
                    chk("rst_mu_we", mu_we, 0);
                    chk("rst_mu_addr", mu_addr, 0);
                    chk("rst_mu_data", mu_data, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_irq", irq_done, 0);
                    prev_start = 1'b0;
                end else begin
                    done_now = 1'b0;
                    while (ev_q.size() > 0) begin
                        op = ev_q.pop_front();
                        done_now = 1'b1;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL op_expected: actual op we=%0d addr %h, required no bus operation", op.we, op.addr);
                        end else begin
                            e = exp_q.pop_front();
                            chk("op_we", op.we, e.we);
                            chk("op_addr", op.addr, e.addr);
                            if (e.we) chk("op_data", op.data, e.data);
                            if (exp_q.size() == 0) m_end_c = op.cyc;
                        end
                    end
                    while (go_q.size() > 0) begin
                        g = go_q.pop_front();
                        if (!m_active) accept(g);
                    end

                    exp_busy = m_active && (cyc >= m_go_c + 1) && (m_end_c < 0 || cyc <= m_end_c + 1);
                    exp_irq  = m_active && (m_end_c >= 0) && (cyc == m_end_c + 2);
                    chk("busy", busy, exp_busy);
                    chk("irq_done", irq_done, exp_irq);
                    if (irq_done) irq_log.push_back(cyc);
                    if (mu_start) start_cycles++;

                    if (exp_q.size() == 0 || done_now) begin
                        chk("start_low", mu_start, 0);
                    end else if (mu_start) begin
                        chk("req_we", mu_we, exp_q[0].we);
                        chk("req_addr", mu_addr, exp_q[0].addr);
                        if (exp_q[0].we) chk("req_data", mu_data, exp_q[0].data);
                    end
                    if (mu_start && prev_start && !done_now) begin
                        chk("stable_addr", mu_addr, prev_addr);
                        chk("stable_we", mu_we, prev_we);
                        chk("stable_data", mu_data, prev_data);
                    end
                    prev_start = mu_start;
                    prev_addr  = mu_addr;
                    prev_we    = mu_we;
                    prev_data  = mu_data;
                    if (exp_irq) m_active = 1'b0;
                end
            end
            // memory responder: done after lat cycles of mu_start, optional stray dones
            forever begin
                @(negedge clk);
                #2;
                if (reset) begin
                    mu_done = 1'b0;
                    k = 0;
                end else if (mu_done) begin
                    mu_done = 1'b0;
                end else if (inject_ack != inject_req) begin
                    inject_ack++;
                    mu_done = 1'b1;
                    mu_q    = $urandom;
                end else if (mu_start) begin
                    if (!hold) begin
                        k++;
                        if (k >= lat) begin
                            k = 0;
                            rop.cyc  = cyc;
                            rop.we   = mu_we;
                            rop.addr = mu_addr;
                            rop.data = mu_we ? mu_data : mem_val(mu_addr);
                            mu_q     = mu_we ? $urandom : rop.data;
                            mu_done  = 1'b1;
                            ev_q.push_back(rop);
                            log_q.push_back(rop);
                        end
                    end
                end else if (spur_en && $urandom_range(0, 4) == 0) begin
                    mu_done = 1'b1;
                    mu_q    = $urandom;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_mu_start", mu_start, 0);
        chk("init_mu_addr", mu_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // basic 3-word copy, latency 2
        lat = 2; spur_en = 1'b0; clear_logs();
        issue_go(32'h100, 32'h200, 3, 1'b0, '0);
        wait_idle(500, 1'b0);
        chk("t1_nops", log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) begin
                chk("t1_addr", log_q[i].addr, t1_addr[i]);
                chk("t1_we", log_q[i].we, t1_we[i]);
                if (t1_we[i]) chk("t1_data_match", log_q[i].data, log_q[i-1].data);
            end
        end
        chk("t1_irq_count", irq_log.size(), 1);
        chk("t1_busy_after", busy, 0);

        // zero length
        clear_logs();
        issue_go(32'h700, 32'h800, 0, 1'b0, '0);
        wait_idle(100, 1'b0);
        chk("t2_irq_count", irq_log.size(), 1);
        if (irq_log.size() > 0) chk("t2_irq_delay", irq_log[0] - last_go_c, 2);
        chk("t2_no_start", start_cycles, 0);

        // go during a transfer is ignored
        lat = 3; clear_logs();
        issue_go(32'h300, 32'h400, 4, 1'b0, '0);
        repeat (5) @(negedge clk);
        issue_go(32'h999, 32'hAAA, 2, 1'b0, '0);
        wait_idle(500, 1'b0);
        chk("t3_nops", log_q.size(), 8);
        if (log_q.size() == 8) begin
            chk("t3_first_rd", log_q[0].addr, 32'h300);
            chk("t3_last_rd", log_q[6].addr, 32'h303);
            chk("t3_last_wr", log_q[7].addr, 32'h403);
        end
        chk("t3_irq_count", irq_log.size(), 1);

        // reset while a write waits for done; late done afterwards
        lat = 2; clear_logs();
        issue_go(32'h500, 32'h600, 3, 1'b0, '0);
        begin
            int n = 0;
            while (!(mu_start && mu_we) && n < 200) begin
                @(negedge clk);
                n++;
            end
            hold = 1'b1;
            chk("t4_wr_wait", 32'(mu_start && mu_we), 1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_start_async", mu_start, 0);
        chk("t4_busy_async", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        inject_req++;
        hold = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_no_write", count_we(1'b1), 0);
        chk("t4_no_irq", irq_log.size(), 0);
        chk("t4_start_low", mu_start, 0);

        // address wrap
        clear_logs();
        issue_go(32'hFFFF_FFFF, 32'h10, 2, 1'b0, '0);
        wait_idle(500, 1'b0);
        chk("t5_nops", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t5_rd0", log_q[0].addr, 32'hFFFF_FFFF);
            chk("t5_rd1_wrap", log_q[2].addr, 32'h0);
            chk("t5_wr1", log_q[3].addr, 32'h11);
        end

`ifdef DMA_MU_MASTER_FILL_EN
        // fill mode
        clear_logs();
        issue_go(32'h0, 32'h900, 4, 1'b1, 32'hDEAD_BEEF);
        wait_idle(500, 1'b0);
        chk("t6_writes", count_we(1'b1), 4);
        chk("t6_reads", count_we(1'b0), 0);
        foreach (log_q[i]) chk("t6_pattern", log_q[i].data, 32'hDEAD_BEEF);
`endif

        // randomized transfers with stray go pulses and stray dones
        for (int it = 0; it < 30; it++) begin
            logic [31:0] s;
            lat     = $urandom_range(1, 4);
            spur_en = 1'($urandom);
            s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            issue_go(s, $urandom, $urandom_range(0, 6), 1'($urandom), $urandom);
            wait_idle(3000, 1'b1);
        end
        spur_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
